// File: rtl/banked_ram.sv
// Byte-addressed RAM split into LANES interleaved banks, one multi-lane read and
// one multi-lane write per cycle, with optional zero-fill after reset.
module banked_ram #(
  parameter int          ADDRBITS       = 10,
  parameter int          LANES          = 2,
  parameter logic [15:0] RAMBASE        = 16'(32'h4000 - (32'd1 << ADDRBITS)),
  parameter bit          OUTREG         = 1'b0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        dread_addr,
  input  logic               dread_en,
  output logic [8*LANES-1:0] dread_data,
  output logic               dread_valid,
  output logic               dread_oor,
  input  logic [15:0]        dwrite_addr,
  input  logic [8*LANES-1:0] dwrite_data,
  input  logic [LANES-1:0]   dwrite_en,
  output logic               ready
);
  // state | meaning
  // CLEAR | zero-filling one row of every bank per cycle, accesses refused
  // RUN   | normal operation, ready=1
  localparam int LB   = $clog2(LANES);
  localparam int RB   = ADDRBITS - LB;
  localparam int ROWS = 1 << RB;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state;
  logic [RB-1:0] clr_row;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_row <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_row <= clr_row + RB'(1);
          if (clr_row == RB'(ROWS - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        default: ready <= 1'b1;
      endcase
    end
  end

  logic acc;
  assign acc = ready && !reset;

  // Offsets from RAMBASE; a lane is in range iff no offset bits above ADDRBITS are set.
  logic [15:0]      w_off [LANES];
  logic [15:0]      r_off [LANES];
  logic [LANES-1:0] w_in, r_in;

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_off[k] = 16'(dwrite_addr + 16'(k) - RAMBASE);
      r_off[k] = 16'(dread_addr + 16'(k) - RAMBASE);
      w_in[k]  = (w_off[k] >> ADDRBITS) == 16'd0;
      r_in[k]  = (r_off[k] >> ADDRBITS) == 16'd0;
    end
  end

  // Consecutive bytes land in distinct banks, so each bank sees exactly one lane.
  logic [LANES-1:0] b_we;
  logic [RB-1:0]    b_wrow  [LANES];
  logic [RB-1:0]    b_rrow  [LANES];
  logic [7:0]       b_wdata [LANES];
  logic [7:0]       bank_q  [LANES];

  always_comb begin
    b_we = '0;
    for (int b = 0; b < LANES; b++) begin
      b_wrow[b]  = '0;
      b_rrow[b]  = '0;
      b_wdata[b] = 8'h00;
      for (int k = 0; k < LANES; k++) begin
        if (w_off[k][LB-1:0] == LB'(b)) begin
          b_wrow[b]  = w_off[k][ADDRBITS-1:LB];
          b_wdata[b] = dwrite_data[8*k +: 8];
          b_we[b]    = acc && w_in[k] && dwrite_en[k];
        end
        if (r_off[k][LB-1:0] == LB'(b))
          b_rrow[b] = r_off[k][ADDRBITS-1:LB];
      end
      if (state == CLEAR && !reset) begin
        b_we[b]    = 1'b1;
        b_wrow[b]  = clr_row;
        b_wdata[b] = 8'h00;
      end
    end
  end

  for (genvar b = 0; b < LANES; b++) begin : g_bank
    logic [7:0] mem [ROWS];
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (b_we[b]) mem[b_wrow[b]] <= b_wdata[b];
    end

    // Forward a same-cycle write so reads see the new byte.
    always_ff @(posedge clk) begin
      if (reset)
        q <= 8'h00;
      else if (acc && dread_en)
        q <= (b_we[b] && b_wrow[b] == b_rrow[b]) ? b_wdata[b] : mem[b_rrow[b]];
    end

    assign bank_q[b] = q;
  end

  logic [LB-1:0]      lane_bank [LANES];
  logic [LANES-1:0]   lane_oor;
  logic               valid1;
  logic [8*LANES-1:0] data1;
  logic               oor1;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid1   <= 1'b0;
      lane_oor <= '0;
      for (int k = 0; k < LANES; k++) lane_bank[k] <= '0;
    end else begin
      valid1 <= acc && dread_en;
      if (acc && dread_en) begin
        lane_oor <= ~r_in;
        for (int k = 0; k < LANES; k++) lane_bank[k] <= r_off[k][LB-1:0];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++)
      data1[8*k +: 8] = lane_oor[k] ? 8'h00 : bank_q[lane_bank[k]];
    oor1 = |lane_oor;
  end

  if (OUTREG) begin : g_outreg
    logic               v2, o2;
    logic [8*LANES-1:0] d2;

    always_ff @(posedge clk) begin
      if (reset) begin
        v2 <= 1'b0;
        d2 <= '0;
        o2 <= 1'b0;
      end else begin
        v2 <= valid1;
        if (valid1) begin
          d2 <= data1;
          o2 <= oor1;
        end
      end
    end

    assign dread_valid = v2;
    assign dread_data  = d2;
    assign dread_oor   = o2;
  end else begin : g_direct
    assign dread_valid = valid1;
    assign dread_data  = data1;
    assign dread_oor   = oor1;
  end
endmodule

// File: tb/tb_banked_ram.sv
// Checks banked_ram (default and OUTREG=1 instances, shared stimulus) against a
// flat byte-array model of the address space.
module tb_banked_ram;
  logic        clk, reset;
  logic [15:0] dread_addr, dwrite_addr, dwrite_data;
  logic        dread_en;
  logic [1:0]  dwrite_en;
  logic [15:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1, rd_oor0, rd_oor1, ready0, ready1;

  banked_ram dut0 (
    .clk(clk), .reset(reset), .dread_addr(dread_addr), .dread_en(dread_en),
    .dread_data(rd_data0), .dread_valid(rd_valid0), .dread_oor(rd_oor0),
    .dwrite_addr(dwrite_addr), .dwrite_data(dwrite_data), .dwrite_en(dwrite_en),
    .ready(ready0));

  banked_ram #(.OUTREG(1)) dut1 (
    .clk(clk), .reset(reset), .dread_addr(dread_addr), .dread_en(dread_en),
    .dread_data(rd_data1), .dread_valid(rd_valid1), .dread_oor(rd_oor1),
    .dwrite_addr(dwrite_addr), .dwrite_data(dwrite_data), .dwrite_en(dwrite_en),
    .ready(ready1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  mdl [65536];
  logic [15:0] ld0, ld1, p_d;
  logic        lo0, lo1, p_v, p_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic bit in_range(input logic [15:0] b);
    return int'(b) >= 16'h3c00 && int'(b) < 16'h3c00 + 1024;
  endfunction

  task automatic clear_model();
    for (int i = 16'h3c00; i < 16'h4000; i++) mdl[i] = 8'h00;
  endtask

  task automatic flush_expect();
    ld0 = 16'h0; lo0 = 1'b0; ld1 = 16'h0; lo1 = 1'b0;
    p_v = 1'b0; p_d = 16'h0; p_o = 1'b0;
  endtask

  // One RUN-mode cycle: write applied to the model before the read (write-first).
  task automatic step(input bit ren, input logic [15:0] ra, input logic [1:0] we,
                      input logic [15:0] wa, input logic [15:0] wd);
    logic [15:0] b, ed;
    logic        eo;
    dread_en = ren; dread_addr = ra; dwrite_en = we; dwrite_addr = wa; dwrite_data = wd;
    for (int k = 0; k < 2; k++) begin
      b = 16'(wa + 16'(k));
      if (we[k] && in_range(b)) mdl[b] = wd[8*k +: 8];
    end
    ed = 16'h0; eo = 1'b0;
    for (int k = 0; k < 2; k++) begin
      b = 16'(ra + 16'(k));
      if (in_range(b)) ed[8*k +: 8] = mdl[b];
      else eo = 1'b1;
    end
    @(posedge clk); #1;
    if (ren) begin ld0 = ed; lo0 = eo; end
    chk("valid0", 32'(rd_valid0), 32'(ren));
    chk("data0", 32'(rd_data0), 32'(ld0));
    chk("oor0", 32'(rd_oor0), 32'(lo0));
    if (p_v) begin ld1 = p_d; lo1 = p_o; end
    chk("valid1", 32'(rd_valid1), 32'(p_v));
    chk("data1", 32'(rd_data1), 32'(ld1));
    chk("oor1", 32'(rd_oor1), 32'(lo1));
    p_v = ren; p_d = ed; p_o = eo;
    dread_en = 1'b0; dwrite_en = 2'b00;
  endtask

  // Reset already released; reads and writes held active to prove they are refused.
  task automatic wait_ready(input string tag);
    int n;
    bit seen_v;
    n = 0; seen_v = 0;
    dread_en = 1'b1; dread_addr = 16'h3c10;
    dwrite_en = 2'b11; dwrite_addr = 16'h3c10; dwrite_data = 16'hffff;
    while (!ready0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (rd_valid0 || rd_valid1) seen_v = 1;
    end
    dread_en = 1'b0; dwrite_en = 2'b00;
    chk({tag, "_cycles"}, 32'(n), 32'd512);
    chk({tag, "_ready1"}, 32'(ready1), 32'd1);
    chk({tag, "_no_valid"}, 32'(seen_v), 32'd0);
    clear_model();
    flush_expect();
  endtask

  function automatic logic [15:0] pick();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 16'(16'h3c00 + $urandom_range(0, 63));
    else if (r == 7) return 16'(16'h3bfc + $urandom_range(0, 7));
    else if (r == 8) return 16'(16'h3ffc + $urandom_range(0, 7));
    else             return 16'($urandom);
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) mdl[i] = 8'h00;
    flush_expect();
    reset = 1'b1; dread_en = 1'b0; dread_addr = 16'h0;
    dwrite_en = 2'b00; dwrite_addr = 16'h0; dwrite_data = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready0), 32'd0);
    chk("rst_valid", 32'({rd_valid0, rd_valid1}), 32'd0);
    chk("rst_data", 32'({rd_data0, rd_data1}), 32'd0);
    chk("rst_oor", 32'({rd_oor0, rd_oor1}), 32'd0);
    reset = 1'b0;
    wait_ready("clear1");

    step(1, 16'h3c00, 2'b00, 16'h0, 16'h0);
    chk("rd_3c00", 32'(rd_data0), 32'h0000);
    step(0, 16'h0, 2'b11, 16'h3c10, 16'hbeef);
    step(1, 16'h3c10, 2'b00, 16'h0, 16'h0);
    chk("rd_3c10", 32'(rd_data0), 32'hbeef);
    step(1, 16'h3c11, 2'b00, 16'h0, 16'h0);
    chk("rd_3c11", 32'(rd_data0), 32'h00be);
    step(0, 16'h0, 2'b01, 16'h3c21, 16'h1234);
    step(1, 16'h3c20, 2'b00, 16'h0, 16'h0);
    chk("rd_3c20", 32'(rd_data0), 32'h3400);
    step(0, 16'h0, 2'b11, 16'h3bff, 16'haaaa);
    step(1, 16'h3bff, 2'b00, 16'h0, 16'h0);
    chk("rd_3bff", 32'({rd_oor0, rd_data0}), 32'h1aa00);
    step(1, 16'h3fff, 2'b00, 16'h0, 16'h0);
    chk("rd_3fff_hi", 32'(rd_data0[15:8]), 32'h00);
    chk("rd_3fff_oor", 32'(rd_oor0), 32'd1);
    step(1, 16'h3c40, 2'b11, 16'h3c40, 16'h5a5a);
    chk("wr_first", 32'(rd_data0), 32'h5a5a);
    step(0, 16'h0, 2'b00, 16'h0, 16'h0);
    step(0, 16'h0, 2'b00, 16'h0, 16'h0);
    for (int i = 0; i < 6; i++) step(1, 16'(16'h3c0e + 2 * i), 2'b00, 16'h0, 16'h0);
    step(1, 16'hffff, 2'b11, 16'hffff, 16'h7777);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] ra;
      ra = pick();
      step($urandom_range(0, 3) != 0, ra, 2'($urandom),
           ($urandom_range(0, 3) == 0) ? ra : pick(), 16'($urandom));
    end

    // Read sampled just before reset must not surface from the pipelined instance.
    step(1, 16'h3c10, 2'b00, 16'h0, 16'h0);
    reset = 1'b1; dread_en = 1'b1; dread_addr = 16'h3c10;
    @(posedge clk); #1;
    chk("inflight_v0", 32'(rd_valid0), 32'd0);
    chk("inflight_v1", 32'(rd_valid1), 32'd0);
    chk("inflight_data", 32'({rd_data0, rd_data1}), 32'd0);
    chk("inflight_ready", 32'({ready0, ready1}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    dread_en = 1'b0;
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("mid_clear_ready", 32'({ready0, ready1}), 32'd0);
    reset = 1'b1; dread_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_ready("clear2");

    step(1, 16'h3c10, 2'b00, 16'h0, 16'h0);
    step(1, 16'h3c40, 2'b00, 16'h0, 16'h0);
    step(1, 16'h3ffe, 2'b00, 16'h0, 16'h0);
    step(0, 16'h0, 2'b00, 16'h0, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
